// File: rtl/dvg_pkg.sv
// Shared definitions for the DVG fetch/decode front end: opcodes, FSM states,
// command kind encoding and the sign-magnitude conversion helper.
package dvg_pkg;

   localparam logic [3:0] OP_LABS = 4'hA;
   localparam logic [3:0] OP_HALT = 4'hB;
   localparam logic [3:0] OP_JSRL = 4'hC;
   localparam logic [3:0] OP_RTSL = 4'hD;
   localparam logic [3:0] OP_JMPL = 4'hE;
   localparam logic [3:0] OP_SVEC = 4'hF;

   localparam logic KIND_VEC  = 1'b0;
   localparam logic KIND_LABS = 1'b1;

   typedef enum logic [3:0] {
      ST_IDLE,
      ST_RD_LO,
      ST_RD_HI,
      ST_CAP_HI,
      ST_RD2_LO,
      ST_RD2_HI,
      ST_CAP2_HI,
      ST_EXEC,
      ST_EMIT
   } state_e;

   // A negative zero negates to zero, so -0 needs no special case.
   function automatic logic [10:0] sm_to_tc(input logic sign, input logic [9:0] mag);
      logic [10:0] m;
      m = {1'b0, mag};
      return sign ? (~m + 11'd1) : m;
   endfunction

endpackage

// File: rtl/dvg_retstack.sv
// Return-address LIFO for JSRL/RTSL. Wraps modulo DEPTH by default; with
// DVG_STACK_GUARD_EN it refuses to push when full or pop when empty.
module dvg_retstack #(
   parameter int DEPTH = 4,
   parameter int W     = 12
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         clear,
   input  logic         push,
   input  logic         pop,
   input  logic [W-1:0] push_data,
   output logic [W-1:0] pop_data,
   output logic         full,
   output logic         empty
);

   localparam int            PW       = $clog2(DEPTH);
   localparam logic [PW:0]   CNT_FULL = (PW+1)'(DEPTH);

   logic [PW-1:0] sp_q, sp_d;
   logic [PW:0]   cnt_q, cnt_d;
   logic [W-1:0]  mem_q [DEPTH];
   logic          do_push, do_pop;

   assign full  = (cnt_q == CNT_FULL);
   assign empty = (cnt_q == '0);

`ifdef DVG_STACK_GUARD_EN
   assign do_push = push & ~full;
   assign do_pop  = pop & ~empty;
`else
   assign do_push = push;
   assign do_pop  = pop;
`endif

   // Pop decrements first, so the value returned sits just below sp.
   assign pop_data = mem_q[sp_q - PW'(1)];

   always_comb begin
      sp_d  = sp_q;
      cnt_d = cnt_q;
      if (clear) begin
         sp_d  = '0;
         cnt_d = '0;
      end else if (do_push) begin
         sp_d = sp_q + PW'(1);
         if (!full) cnt_d = cnt_q + (PW+1)'(1);
      end else if (do_pop) begin
         sp_d = sp_q - PW'(1);
         if (!empty) cnt_d = cnt_q - (PW+1)'(1);
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sp_q  <= '0;
         cnt_q <= '0;
      end else begin
         sp_q  <= sp_d;
         cnt_q <= cnt_d;
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem_q[sp_q] <= push_data;
   end

endmodule

// File: rtl/dvg_fetch.sv
// DVG display-list fetch/decode: walks 16-bit words over an 8-bit read port,
// runs control flow and emits beam commands. Optional macro: DVG_STACK_GUARD_EN.
module dvg_fetch
   import dvg_pkg::*;
#(
   parameter int AW          = 13,
   parameter int STACK_DEPTH = 4
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          go,
   output logic          halted,
   output logic          mem_rd,
   output logic [AW-1:0] mem_addr,
   input  logic [7:0]    mem_din,
   output logic          cmd_valid,
   input  logic          cmd_ready,
   output logic          cmd_kind,
   output logic [3:0]    cmd_scale,
   output logic [10:0]   cmd_x,
   output logic [10:0]   cmd_y,
   output logic [3:0]    cmd_z,
   output logic          stack_err
);

   localparam int PCW = AW - 1;

`ifdef DVG_STACK_GUARD_EN
   localparam logic GUARD_EN = 1'b1;
`else
   localparam logic GUARD_EN = 1'b0;
`endif

   state_e         state_q, state_d;
   logic [PCW-1:0] pc_q, pc_d;
   logic [7:0]     lo_q, lo_d;
   logic [15:0]    w0_q, w0_d;
   logic [14:0]    w1_q, w1_d;   // second word without bit 11, which no opcode reads
   logic           halted_q, halted_d, err_q, err_d;
   logic           kind_q, kind_d;
   logic [3:0]     scale_q, scale_d, z_q, z_d;
   logic [10:0]    x_q, x_d, y_q, y_d;
   logic           hi_sel, st_clear, st_push, st_pop, st_full, st_empty;
   logic [PCW-1:0] st_pop_data;
   logic [3:0]     op;

   assign op        = w0_q[15:12];
   assign mem_addr  = {pc_q, hi_sel};
   assign halted    = halted_q;
   assign stack_err = err_q;
   assign cmd_kind  = kind_q;
   assign cmd_scale = scale_q;
   assign cmd_x     = x_q;
   assign cmd_y     = y_q;
   assign cmd_z     = z_q;

   dvg_retstack #(.DEPTH(STACK_DEPTH), .W(PCW)) u_stack (
      .clk       (clk),
      .reset     (reset),
      .clear     (st_clear),
      .push      (st_push),
      .pop       (st_pop),
      .push_data (pc_q),
      .pop_data  (st_pop_data),
      .full      (st_full),
      .empty     (st_empty)
   );

   // Handshake: cmd_valid rises in EMIT with every cmd_* field held stable and
   // stays up until the cycle cmd_valid & cmd_ready, after which it drops.
   always_comb begin
      state_d   = state_q;
      pc_d      = pc_q;
      lo_d      = lo_q;
      w0_d      = w0_q;
      w1_d      = w1_q;
      halted_d  = halted_q;
      err_d     = err_q;
      kind_d    = kind_q;
      scale_d   = scale_q;
      x_d       = x_q;
      y_d       = y_q;
      z_d       = z_q;
      mem_rd    = 1'b0;
      hi_sel    = 1'b0;
      cmd_valid = 1'b0;
      st_clear  = 1'b0;
      st_push   = 1'b0;
      st_pop    = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (go) begin
               pc_d     = '0;
               st_clear = 1'b1;
               halted_d = 1'b0;
               state_d  = ST_RD_LO;
            end
         end
         ST_RD_LO: begin
            mem_rd  = 1'b1;
            state_d = ST_RD_HI;
         end
         ST_RD_HI: begin
            mem_rd  = 1'b1;
            hi_sel  = 1'b1;
            lo_d    = mem_din;
            state_d = ST_CAP_HI;
         end
         ST_CAP_HI: begin
            w0_d    = {mem_din, lo_q};
            pc_d    = pc_q + PCW'(1);
            state_d = (mem_din[7:4] <= OP_LABS) ? ST_RD2_LO : ST_EXEC;
         end
         ST_RD2_LO: begin
            mem_rd  = 1'b1;
            state_d = ST_RD2_HI;
         end
         ST_RD2_HI: begin
            mem_rd  = 1'b1;
            hi_sel  = 1'b1;
            lo_d    = mem_din;
            state_d = ST_CAP2_HI;
         end
         ST_CAP2_HI: begin
            w1_d    = {mem_din[7:4], mem_din[2:0], lo_q};
            pc_d    = pc_q + PCW'(1);
            state_d = ST_EXEC;
         end
         ST_EXEC: begin
            case (op)
               OP_HALT: begin
                  halted_d = 1'b1;
                  state_d  = ST_IDLE;
               end
               OP_JSRL, OP_RTSL: begin
                  if (GUARD_EN && ((op == OP_JSRL) ? st_full : st_empty)) begin
                     err_d    = 1'b1;
                     halted_d = 1'b1;
                     state_d  = ST_IDLE;
                  end else begin
                     st_push = (op == OP_JSRL);
                     st_pop  = (op == OP_RTSL);
                     pc_d    = (op == OP_JSRL) ? PCW'(w0_q[11:0]) : st_pop_data;
                     state_d = ST_RD_LO;
                  end
               end
               OP_JMPL: begin
                  pc_d    = PCW'(w0_q[11:0]);
                  state_d = ST_RD_LO;
               end
               OP_LABS: begin
                  kind_d  = KIND_LABS;
                  scale_d = w1_q[14:11];
                  x_d     = {1'b0, w1_q[9:0]};
                  y_d     = {1'b0, w0_q[9:0]};
                  z_d     = 4'd0;
                  state_d = ST_EMIT;
               end
               OP_SVEC: begin
                  kind_d  = KIND_VEC;
                  scale_d = 4'd2 + {2'b00, w0_q[11], w0_q[3]};
                  x_d     = sm_to_tc(w0_q[2], {w0_q[1:0], 8'h00});
                  y_d     = sm_to_tc(w0_q[10], {w0_q[9:8], 8'h00});
                  z_d     = w0_q[7:4];
                  state_d = ST_EMIT;
               end
               default: begin
                  kind_d  = KIND_VEC;
                  scale_d = op;
                  x_d     = sm_to_tc(w1_q[10], w1_q[9:0]);
                  y_d     = sm_to_tc(w0_q[10], w0_q[9:0]);
                  z_d     = w1_q[14:11];
                  state_d = ST_EMIT;
               end
            endcase
         end
         ST_EMIT: begin
            cmd_valid = 1'b1;
            if (cmd_ready) state_d = ST_RD_LO;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q  <= ST_IDLE;
         pc_q     <= '0;
         lo_q     <= '0;
         w0_q     <= '0;
         w1_q     <= '0;
         halted_q <= 1'b1;
         err_q    <= 1'b0;
         kind_q   <= 1'b0;
         scale_q  <= '0;
         x_q      <= '0;
         y_q      <= '0;
         z_q      <= '0;
      end else begin
         state_q  <= state_d;
         pc_q     <= pc_d;
         lo_q     <= lo_d;
         w0_q     <= w0_d;
         w1_q     <= w1_d;
         halted_q <= halted_d;
         err_q    <= err_d;
         kind_q   <= kind_d;
         scale_q  <= scale_d;
         x_q      <= x_d;
         y_q      <= y_d;
         z_q      <= z_d;
      end
   end

endmodule

// File: tb/tb_dvg_fetch.sv
// Self-checking bench for dvg_fetch: directed display lists plus random programs
// scored against a word-level interpreter of the display-list rules.
module tb_dvg_fetch;

   localparam int AW    = 13;
   localparam int DEPTH = 4;
`ifdef DVG_STACK_GUARD_EN
   localparam bit GUARD = 1'b1;
`else
   localparam bit GUARD = 1'b0;
`endif

   // ---------------- clock / reset / DUT ----------------
   logic          clk = 1'b0;
   logic          reset, go, cmd_ready;
   logic          halted, mem_rd, cmd_valid, cmd_kind, stack_err;
   logic [AW-1:0] mem_addr;
   logic [7:0]    mem_din = 8'h00;
   logic [3:0]    cmd_scale, cmd_z;
   logic [10:0]   cmd_x, cmd_y;

   always #5 clk = ~clk;

   dvg_fetch #(.AW(AW), .STACK_DEPTH(DEPTH)) dut (
      .clk(clk), .reset(reset), .go(go), .halted(halted),
      .mem_rd(mem_rd), .mem_addr(mem_addr), .mem_din(mem_din),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_kind(cmd_kind),
      .cmd_scale(cmd_scale), .cmd_x(cmd_x), .cmd_y(cmd_y), .cmd_z(cmd_z),
      .stack_err(stack_err)
   );

   // Synchronous vector memory: data appears the cycle after the strobe.
   logic [7:0] mem [0:(1<<AW)-1];
   always @(posedge clk) if (mem_rd) mem_din <= mem[mem_addr];

   // ---------------- scoreboard ----------------
   int            n_checks = 0;
   int            n_pass   = 0;
   int            n_cmds   = 0;
   int            ready_mode = 0;   // 0 random, 1 held low, 2 held high
   logic [30:0]   exp_q[$];
   logic [AW-1:0] rd_log[$];

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
   endtask

   function automatic logic [30:0] pack_cmd(input logic kind, input logic [3:0] scale,
                                            input logic [10:0] x, input logic [10:0] y,
                                            input logic [3:0] z);
      return {kind, scale, x, y, z};
   endfunction

   function automatic logic [10:0] tc(input int v);
      return v[10:0];
   endfunction

   function automatic logic [10:0] sgnmag(input logic s, input int mag);
      return tc(s ? -mag : mag);
   endfunction

   always @(negedge clk) begin
      if (mem_rd) rd_log.push_back(mem_addr);
      case (ready_mode)
         0:       cmd_ready = 1'($urandom_range(0, 1));
         1:       cmd_ready = 1'b0;
         default: cmd_ready = 1'b1;
      endcase
      if (cmd_valid && cmd_ready) begin
         n_cmds++;
         if (exp_q.size() == 0) check("cmd_extra", 32'(exp_q.size()), 32'd1);
         else check("cmd", 32'(pack_cmd(cmd_kind, cmd_scale, cmd_x, cmd_y, cmd_z)), 32'(exp_q.pop_front()));
      end
   end

   // ---------------- memory helpers and reference interpreter ----------------
   task automatic clear_mem();
      foreach (mem[i]) mem[i] = 8'h00;
   endtask

   task automatic put_word(input int p, input logic [15:0] w);
      mem[2*p]   = w[7:0];
      mem[2*p+1] = w[15:8];
   endtask

   function automatic logic [15:0] rd_word(input int p);
      return {mem[2*p+1], mem[2*p]};
   endfunction

   // Executes the display list word by word; returns 1 if a stack fault stops it.
   task automatic model_run(output bit m_err);
      int pc, ptr, cnt, op;
      int stk[DEPTH];
      logic [15:0] w0, w1;
      pc = 0; ptr = 0; cnt = 0; m_err = 1'b0;
      for (int step = 0; step < 4000; step++) begin
         w0 = rd_word(pc);
         pc = (pc + 1) % 4096;
         op = int'(w0[15:12]);
         w1 = 16'h0;
         if (op <= 10) begin
            w1 = rd_word(pc);
            pc = (pc + 1) % 4096;
         end
         if (op <= 9) begin
            exp_q.push_back(pack_cmd(1'b0, 4'(op), sgnmag(w1[10], int'(w1[9:0])),
                                     sgnmag(w0[10], int'(w0[9:0])), w1[15:12]));
         end else if (op == 10) begin
            exp_q.push_back(pack_cmd(1'b1, w1[15:12], tc(int'(w1[9:0])), tc(int'(w0[9:0])), 4'd0));
         end else if (op == 11) begin
            return;
         end else if (op == 12) begin
            if (GUARD && cnt == DEPTH) begin m_err = 1'b1; return; end
            stk[ptr] = pc;
            ptr = (ptr + 1) % DEPTH;
            if (cnt < DEPTH) cnt++;
            pc = int'(w0[11:0]);
         end else if (op == 13) begin
            if (GUARD && cnt == 0) begin m_err = 1'b1; return; end
            ptr = (ptr + DEPTH - 1) % DEPTH;
            pc = stk[ptr];
            if (cnt > 0) cnt--;
         end else if (op == 14) begin
            pc = int'(w0[11:0]);
         end else begin
            exp_q.push_back(pack_cmd(1'b0, 4'(2 + 2*int'(w0[11]) + int'(w0[3])),
                                     sgnmag(w0[2], 256*int'(w0[1:0])),
                                     sgnmag(w0[10], 256*int'(w0[9:8])), w0[7:4]));
         end
      end
   endtask

   task automatic gen_prog(input int n_body, input int n_sub);
      int p;
      clear_mem();
      p = 0;
      for (int k = 0; k < n_body; k++) begin
         case ($urandom_range(0, 5))
            0: begin put_word(p, {4'($urandom_range(0, 9)), 12'($urandom)}); put_word(p+1, 16'($urandom)); p += 2; end
            1: begin put_word(p, {4'hA, 12'($urandom)}); put_word(p+1, 16'($urandom)); p += 2; end
            3: begin put_word(p, 16'hE000 | 16'(p + 2)); put_word(p+1, 16'($urandom)); p += 2; end
            4: begin put_word(p, 16'hC200); p += 1; end
            default: begin put_word(p, {4'hF, 12'($urandom)}); p += 1; end
         endcase
      end
      put_word(p, 16'hB000);
      p = 'h200;
      for (int k = 0; k < n_sub; k++) begin
         if ($urandom_range(0, 1) == 1) begin
            put_word(p, {4'hF, 12'($urandom)}); p += 1;
         end else begin
            put_word(p, {4'($urandom_range(0, 9)), 12'($urandom)}); put_word(p+1, 16'($urandom)); p += 2;
         end
      end
      put_word(p, 16'hD000);
   endtask

   // ---------------- driver tasks ----------------
   task automatic apply_reset();
      @(negedge clk);
      reset = 1'b1;
      go    = 1'b0;
      repeat (2) @(negedge clk);
      reset = 1'b0;
   endtask

   task automatic pulse_go();
      @(negedge clk);
      go = 1'b1;
      @(negedge clk);
      go = 1'b0;
   endtask

   task automatic wait_halted(input string tag, input int budget);
      for (int c = 0; c < budget; c++) begin
         @(posedge clk);
         #1;
         if (halted) break;
      end
      check({tag, "_halted"}, 32'(halted), 32'd1);
   endtask

   task automatic wait_valid(input string tag, input int budget);
      for (int c = 0; c < budget; c++) begin
         @(posedge clk);
         #1;
         if (cmd_valid) break;
      end
      check({tag, "_valid"}, 32'(cmd_valid), 32'd1);
   endtask

   task automatic run_prog(input string tag, input bit exp_err, input int budget);
      pulse_go();
      wait_halted(tag, budget);
      check({tag, "_drained"}, 32'(exp_q.size()), 32'd0);
      check({tag, "_stack_err"}, 32'(stack_err), 32'(exp_err));
   endtask

   // ---------------- test sequence ----------------
   logic [30:0] snap;
   bit          stable, quiet, m_err;

   initial begin
      reset = 1'b1;
      go    = 1'b0;
      @(posedge clk);
      #1;
      check("rst_halted", 32'(halted), 32'd1);
      check("rst_valid", 32'(cmd_valid), 32'd0);
      check("rst_mem_rd", 32'(mem_rd), 32'd0);
      check("rst_mem_addr", 32'(mem_addr), 32'd0);
      check("rst_stack_err", 32'(stack_err), 32'd0);
      check("rst_cmd", 32'(pack_cmd(cmd_kind, cmd_scale, cmd_x, cmd_y, cmd_z)), 32'd0);
      apply_reset();

      // Immediate HALT: two byte reads then idle within four cycles.
      clear_mem();
      put_word(0, 16'hB000);
      rd_log.delete();
      n_cmds = 0;
      pulse_go();
      for (int c = 0; c < 4; c++) begin
         @(posedge clk);
         #1;
         if (halted) break;
      end
      check("halt_latency", 32'(halted), 32'd1);
      check("halt_reads", 32'(rd_log.size()), 32'd2);
      if (rd_log.size() == 2) begin
         check("halt_rd0", 32'(rd_log[0]), 32'd0);
         check("halt_rd1", 32'(rd_log[1]), 32'd1);
      end
      check("halt_no_cmd", 32'(n_cmds), 32'd0);

      // LABS then HALT.
      clear_mem();
      put_word(0, 16'hA17F); put_word(1, 16'h1200); put_word(2, 16'hB000);
      exp_q.push_back(pack_cmd(1'b1, 4'd1, tc(512), tc(383), 4'd0));
      run_prog("labs", 1'b0, 200);

      // Long vector with negative y.
      clear_mem();
      put_word(0, 16'h7432); put_word(1, 16'hC064); put_word(2, 16'hB000);
      exp_q.push_back(pack_cmd(1'b0, 4'd7, tc(100), tc(-50), 4'd12));
      run_prog("vctr", 1'b0, 200);

      // Short vector held by a stalled consumer for ten cycles.
      clear_mem();
      put_word(0, 16'hF0F5); put_word(1, 16'hB000);
      exp_q.push_back(pack_cmd(1'b0, 4'd2, tc(-256), tc(0), 4'd15));
      ready_mode = 1;
      pulse_go();
      wait_valid("svec", 50);
      snap = pack_cmd(cmd_kind, cmd_scale, cmd_x, cmd_y, cmd_z);
      check("svec_fields", 32'(snap), 32'(pack_cmd(1'b0, 4'd2, tc(-256), tc(0), 4'd15)));
      stable = 1'b1;
      quiet  = 1'b1;
      for (int c = 0; c < 10; c++) begin
         @(posedge clk);
         #1;
         if (!cmd_valid || pack_cmd(cmd_kind, cmd_scale, cmd_x, cmd_y, cmd_z) != snap) stable = 1'b0;
         if (mem_rd) quiet = 1'b0;
      end
      check("stall_stable", 32'(stable), 32'd1);
      check("stall_no_rd", 32'(quiet), 32'd1);
      rd_log.delete();
      ready_mode = 2;
      wait_halted("svec", 50);
      check("svec_drained", 32'(exp_q.size()), 32'd0);
      check("resume_reads", 32'(rd_log.size()), 32'd2);
      if (rd_log.size() > 0) check("resume_addr", 32'(rd_log[0]), 32'd2);
      ready_mode = 0;

      // Subroutine call and return.
      clear_mem();
      put_word(0, 16'hC010); put_word(1, 16'hB000);
      put_word('h10, 16'hF0F5); put_word('h11, 16'hD000);
      exp_q.push_back(pack_cmd(1'b0, 4'd2, tc(-256), tc(0), 4'd15));
      run_prog("jsrl", 1'b0, 200);

      // Five nested calls: wraps silently, or faults when guarded.
      clear_mem();
      for (int i = 0; i < 5; i++) put_word(i, 16'hC000 | 16'(i + 1));
      put_word(5, 16'hB000);
      run_prog("nest", GUARD, 300);
      apply_reset();
      check("nest_err_cleared", 32'(stack_err), 32'd0);

      // Reset while reading the high byte.
      clear_mem();
      put_word(0, 16'hA17F); put_word(1, 16'h1200); put_word(2, 16'hB000);
      pulse_go();
      @(posedge clk);
      #1;
      check("rdhi_addr", 32'({mem_rd, mem_addr}), 32'({1'b1, 13'd1}));
      reset = 1'b1;
      #1;
      check("rdhi_rst_halted", 32'(halted), 32'd1);
      check("rdhi_rst_rd", 32'(mem_rd), 32'd0);
      @(negedge clk);
      reset = 1'b0;

      // Reset while a command is waiting.
      ready_mode = 1;
      pulse_go();
      wait_valid("emit_rst", 50);
      reset = 1'b1;
      #1;
      check("emit_rst_halted", 32'(halted), 32'd1);
      check("emit_rst_valid", 32'(cmd_valid), 32'd0);
      @(negedge clk);
      reset = 1'b0;
      ready_mode = 0;
      rd_log.delete();
      exp_q.push_back(pack_cmd(1'b1, 4'd1, tc(512), tc(383), 4'd0));
      run_prog("restart", 1'b0, 200);
      if (rd_log.size() > 0) check("restart_addr", 32'(rd_log[0]), 32'd0);

      // Random display lists against the interpreter.
      for (int t = 0; t < 12; t++) begin
         gen_prog($urandom_range(1, 12), $urandom_range(0, 4));
         model_run(m_err);
         run_prog($sformatf("rand%0d", t), m_err, 3000);
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   initial begin
      #5000000;
      $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", n_pass, n_checks);
      $fatal(1);
   end

endmodule
